// File: rtl/oled_cmd_arbiter.sv
// rtl/oled_cmd_arbiter.sv - shares the OLED_interface command port among power, clear and draw requesters
// Optional build macro: OLED_ARB_TIMEOUT_EN adds the per-transaction watchdog (ACK_TIMEOUT clocks).
module oled_cmd_arbiter #(
  parameter logic [1:0] MODE_ON     = 2'b00,
  parameter logic [1:0] MODE_OFF    = 2'b01,
  parameter logic [1:0] MODE_CLR    = 2'b10,
  parameter logic [1:0] MODE_DRAW   = 2'b11,
  parameter int         GAP_CYCLES  = 2,
  parameter int         ACK_TIMEOUT = 1024
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_REQ_PWR,
  input  logic       i_PWR_DIR,
  input  logic       i_REQ_CLR,
  input  logic       i_REQ_DRAW,
  output logic [2:0] o_GNT,
  output logic [2:0] o_DONE,
  output logic [2:0] o_REJECT,
  output logic       o_POWERED,
  output logic       o_BUSY,
  output logic       o_TIMEOUT,
  output logic [1:0] o_OLED_MODE,
  output logic       o_OLED_START,
  input  logic       i_OLED_READY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_GAP} state_t;

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured, a finished transaction drops straight back to arbitration.
  localparam state_t           AFTER_TXN = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t           state, state_nxt;
  logic [2:0]       gnt_nxt, done_nxt, reject_nxt;
  logic [1:0]       mode_nxt;
  logic             start_nxt, powered_nxt, timeout_nxt;
  logic             rr_draw, rr_nxt;
  logic             win_draw;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             tmo_hit;

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int               TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog: held at zero outside a transaction, counts every ISSUE/BUSY clock.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE || state == S_BUSY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == S_ISSUE || state == S_BUSY) && (tmo_cnt == TMO_LAST);
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (ACK_TIMEOUT != 0);
`endif

  assign o_BUSY = (state != S_IDLE);

  // Next-state and next-output decisions: arbitration, handshake tracking, gap timing.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = o_GNT;
    mode_nxt    = o_OLED_MODE;
    start_nxt   = o_OLED_START;
    done_nxt    = 3'b000;
    reject_nxt  = 3'b000;
    powered_nxt = o_POWERED;
    timeout_nxt = 1'b0;
    rr_nxt      = rr_draw;
    gap_nxt     = '0;
    win_draw    = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_OLED_READY && (i_REQ_PWR || i_REQ_CLR || i_REQ_DRAW)) begin
          if (i_REQ_PWR) begin
            if (i_PWR_DIR == o_POWERED) begin
              // Panel already in the requested state: acknowledge without touching the panel.
              done_nxt  = 3'b001;
              state_nxt = AFTER_TXN;
            end else begin
              gnt_nxt   = 3'b001;
              mode_nxt  = i_PWR_DIR ? MODE_ON : MODE_OFF;
              start_nxt = 1'b1;
              state_nxt = S_ISSUE;
            end
          end else begin
            // Draw wins when it is alone or when the round-robin pointer favours it.
            win_draw = i_REQ_DRAW && (!i_REQ_CLR || rr_draw);
            if (!o_POWERED) begin
              reject_nxt = win_draw ? 3'b100 : 3'b010;
              state_nxt  = AFTER_TXN;
            end else begin
              gnt_nxt   = win_draw ? 3'b100 : 3'b010;
              mode_nxt  = win_draw ? MODE_DRAW : MODE_CLR;
              start_nxt = 1'b1;
              rr_nxt    = !win_draw;
              state_nxt = S_ISSUE;
            end
          end
        end
      end

      S_ISSUE: begin
        if (tmo_hit) begin
          start_nxt   = 1'b0;
          gnt_nxt     = 3'b000;
          timeout_nxt = 1'b1;
          state_nxt   = AFTER_TXN;
        end else if (!i_OLED_READY) begin
          start_nxt = 1'b0;
          state_nxt = S_BUSY;
        end
      end

      S_BUSY: begin
        if (tmo_hit) begin
          gnt_nxt     = 3'b000;
          timeout_nxt = 1'b1;
          state_nxt   = AFTER_TXN;
        end else if (i_OLED_READY) begin
          done_nxt = o_GNT;
          gnt_nxt  = 3'b000;
          if (o_GNT[0]) begin
            powered_nxt = (o_OLED_MODE == MODE_ON);
          end
          state_nxt = AFTER_TXN;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs, power flag, round-robin pointer and gap counter.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_GNT        <= 3'b000;
      o_DONE       <= 3'b000;
      o_REJECT     <= 3'b000;
      o_POWERED    <= 1'b0;
      o_TIMEOUT    <= 1'b0;
      o_OLED_MODE  <= MODE_ON;
      o_OLED_START <= 1'b0;
      rr_draw      <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      o_GNT        <= gnt_nxt;
      o_DONE       <= done_nxt;
      o_REJECT     <= reject_nxt;
      o_POWERED    <= powered_nxt;
      o_TIMEOUT    <= timeout_nxt;
      o_OLED_MODE  <= mode_nxt;
      o_OLED_START <= start_nxt;
      rr_draw      <= rr_nxt;
      gap_cnt      <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// tb/tb_oled_cmd_arbiter.sv - self-checking bench for oled_cmd_arbiter
module tb_oled_cmd_arbiter;

  localparam int GAP = 2;
  localparam int ACK = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       req_pwr  = 1'b0;
  logic       pwr_dir  = 1'b0;
  logic       req_clr  = 1'b0;
  logic       req_draw = 1'b0;
  logic       ready    = 1'b1;
  logic [2:0] gnt, done, reject;
  logic       powered, busy, tmo, start;
  logic [1:0] mode;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic oled_auto = 1'b1;
  int   drop_dly  = 3;
  int   rise_dly  = 10;
  logic mon_start = 1'b0;
  logic mon_ready = 1'b1;

  oled_cmd_arbiter #(
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst_n),
    .i_REQ_PWR   (req_pwr),
    .i_PWR_DIR   (pwr_dir),
    .i_REQ_CLR   (req_clr),
    .i_REQ_DRAW  (req_draw),
    .o_GNT       (gnt),
    .o_DONE      (done),
    .o_REJECT    (reject),
    .o_POWERED   (powered),
    .o_BUSY      (busy),
    .o_TIMEOUT   (tmo),
    .o_OLED_MODE (mode),
    .o_OLED_START(start),
    .i_OLED_READY(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // OLED_interface stand-in: after START is seen, READY falls drop_dly clocks later
  // and rises again rise_dly clocks after that.
  initial begin
    forever begin
      @(negedge clk);
      if (oled_auto && start && ready && rst_n) begin
        repeat (drop_dly) @(negedge clk);
        ready = 1'b0;
        repeat (rise_dly) @(negedge clk);
        ready = 1'b1;
      end
    end
  end

  // START must stay up until READY=0 is sampled and fall right after; grant is one-hot meanwhile.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mon_start = 1'b0;
        mon_ready = 1'b1;
      end else begin
        if (mon_start && !mon_ready) begin
          check("start_drop", start, 1'b0);
        end else if (mon_start && !tmo) begin
          check("start_hold", start, 1'b1);
        end
        if (start) check("gnt_onehot", $onehot(gnt), 1'b1);
        mon_start = start;
        mon_ready = ready;
      end
    end
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req_pwr  = 1'b0;
    pwr_dir  = 1'b0;
    req_clr  = 1'b0;
    req_draw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_outcome(output logic [2:0] d, output logic [2:0] r, output logic t,
                              output logic st, output logic [1:0] md, output logic [2:0] g,
                              output int cyc);
    logic got;
    got = 1'b0;
    d = 3'b000; r = 3'b000; t = 1'b0; st = 1'b0; md = 2'b00; g = 3'b000; cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (start && !st) begin
        st = 1'b1;
        md = mode;
        g  = gnt;
      end
      if (done != 3'b000 || reject != 3'b000 || tmo) begin
        d = done; r = reject; t = tmo; got = 1'b1;
      end
    end
    if (!got) bound_fail("outcome_wait");
  endtask

  // The outcome pulse lands in the first gap clock; BUSY must stay high for exactly GAP clocks.
  task automatic check_gap(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_gap_len"}, n, GAP);
  endtask

  task automatic run_txn(input string name, input logic p, input logic dir, input logic c,
                         input logic dr, input logic [2:0] e_done, input logic [2:0] e_rej,
                         input logic e_txn, input logic [1:0] e_mode, input logic e_pwd);
    logic [2:0] d, r, g;
    logic       t, st;
    logic [1:0] md;
    int         cyc, w;
    w = 0;
    while ((busy || !ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) bound_fail({name, "_idle_wait"});
    req_pwr  = p;
    pwr_dir  = dir;
    req_clr  = c;
    req_draw = dr;
    wait_outcome(d, r, t, st, md, g, cyc);
    req_pwr  = 1'b0;
    req_clr  = 1'b0;
    req_draw = 1'b0;
    check({name, "_done"}, d, e_done);
    check({name, "_reject"}, r, e_rej);
    check({name, "_timeout"}, t, 1'b0);
    check({name, "_started"}, st, e_txn);
    if (e_txn) begin
      check({name, "_mode"}, md, e_mode);
      check({name, "_gnt"}, g, e_done);
    end
    check({name, "_gnt_clear"}, gnt, 3'b000);
    check({name, "_powered"}, powered, e_pwd);
    check_gap(name);
  endtask

  typedef struct {
    logic       p, dir, c, dr;
    logic [2:0] e_done, e_rej;
    logic       e_txn;
    logic [1:0] e_mode;
    logic       e_pwd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [2:0] d, r, g;
    logic       t, st, seen;
    logic [1:0] md;
    logic       p, dir, c, dr, wd, m_powered, m_ptr_draw;
    logic [2:0] e_done, e_rej;
    logic       e_txn;
    logic [1:0] e_mode;
    int         cyc;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 2'b00, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 2'b10, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 3'b000, 1'b1, 2'b11, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 2'b10, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 3'b000, 1'b1, 2'b11, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 2'b00, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 1'b1, 2'b11, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, 2'b01, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b010, 1'b0, 2'b00, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {gnt, done, reject, powered, busy, tmo, start, mode}, 15'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", {gnt, done, reject, powered, busy, tmo, start, mode}, 15'h0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].p, vecs[i].dir, vecs[i].c, vecs[i].dr,
              vecs[i].e_done, vecs[i].e_rej, vecs[i].e_txn, vecs[i].e_mode, vecs[i].e_pwd);
    end

    // Power request raised while a draw is in flight wins the next arbitration
    do_reset();
    drop_dly = 2;
    rise_dly = 10;
    run_txn("prio_on", 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 2'b00, 1'b1);
    req_draw = 1'b1;
    cyc = 0;
    while (!(busy && !start && gnt == 3'b100) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) bound_fail("prio_draw_busy");
    req_pwr = 1'b1;
    pwr_dir = 1'b0;
    req_clr = 1'b1;
    wait_outcome(d, r, t, st, md, g, cyc);
    req_draw = 1'b0;
    check("prio_draw_done", d, 3'b100);
    wait_outcome(d, r, t, st, md, g, cyc);
    req_pwr = 1'b0;
    check("prio_off_done", d, 3'b001);
    check("prio_off_started", st, 1'b1);
    check("prio_off_mode", md, 2'b01);
    check("prio_off_powered", powered, 1'b0);
    wait_outcome(d, r, t, st, md, g, cyc);
    req_clr = 1'b0;
    check("prio_clr_reject", r, 3'b010);
    check("prio_clr_no_start", st, 1'b0);
    check_gap("prio_clr");

    // Asynchronous reset during BUSY abandons the transaction
    do_reset();
    run_txn("rst_on", 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 2'b00, 1'b1);
    req_clr = 1'b1;
    cyc = 0;
    while (!(busy && !start && gnt == 3'b010) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) bound_fail("rst_busy_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {gnt, done, reject, powered, busy, tmo, start, mode}, 15'h0);
    req_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done != 3'b000) seen = 1'b1;
    end
    check("no_done_after_reset", seen, 1'b0);
    check("rst_powered", powered, 1'b0);

`ifdef OLED_ARB_TIMEOUT_EN
    // READY never falls: watchdog fires ACK clocks after START
    do_reset();
    drop_dly = 3;
    rise_dly = 5;
    run_txn("to_on", 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 2'b00, 1'b1);
    oled_auto = 1'b0;
    req_clr   = 1'b1;
    cyc = 0;
    while (!start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("to_start_seen", start, 1'b1);
    cyc = 0;
    while (!tmo && done == 3'b000 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    req_clr = 1'b0;
    check("to_latency", cyc, ACK);
    check("to_start_drop", start, 1'b0);
    check("to_no_done", done, 3'b000);
    check("to_gnt_clear", gnt, 3'b000);
    check("to_powered", powered, 1'b1);
    check_gap("to");
    check("to_idle", busy, 1'b0);
    oled_auto = 1'b1;
`endif

    // Randomized transactions against a transaction-level reference model
    do_reset();
    m_powered  = 1'b0;
    m_ptr_draw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      p   = ($urandom_range(0, 3) == 0);
      dir = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      if (!p && !c && !dr) c = 1'b1;
      drop_dly = $urandom_range(0, 4);
      rise_dly = $urandom_range(1, 6);
      e_done = 3'b000;
      e_rej  = 3'b000;
      e_txn  = 1'b0;
      e_mode = 2'b00;
      if (p) begin
        e_done = 3'b001;
        if (dir != m_powered) begin
          e_txn     = 1'b1;
          e_mode    = dir ? 2'b00 : 2'b01;
          m_powered = dir;
        end
      end else begin
        wd = (c && dr) ? m_ptr_draw : dr;
        if (!m_powered) begin
          e_rej = wd ? 3'b100 : 3'b010;
        end else begin
          e_txn      = 1'b1;
          e_done     = wd ? 3'b100 : 3'b010;
          e_mode     = wd ? 2'b11 : 2'b10;
          m_ptr_draw = !wd;
        end
      end
      run_txn($sformatf("rnd%0d", k), p, dir, c, dr, e_done, e_rej, e_txn, e_mode, m_powered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oled_cmd_arbiter.md
Name: oled_cmd_arbiter

Overview:
- Shares the single OLED_interface command port (i_MODE / i_START / o_READY handshake) among three requesters: power control, screen clear and frame draw.
- Tracks panel power state, rejects data commands while the panel is off, and enforces an inter-command gap.
- Sits between the application logic and OLED_interface, and drives that block's i_MODE and i_START directly.

Parameters:
- MODE_ON, 2'b00, OLED_interface mode code for the power-on sequence
- MODE_OFF, 2'b01, mode code for the power-off sequence
- MODE_CLR, 2'b10, mode code for the clear-screen command
- MODE_DRAW, 2'b11, mode code for the frame draw
- GAP_CYCLES, 2, idle clocks forced after each completed or timed-out transaction; 0 means no gap
- ACK_TIMEOUT, 1024, clock limit for one transaction; used only with the optional feature

Ports:
- i_CLK  in  1  system clock; all logic is on the rising edge
- i_RST  in  1  asynchronous, active-low reset
- i_REQ_PWR  in  1  power request; level signal, held until o_DONE[0] or o_REJECT[0]
- i_PWR_DIR  in  1  1 = power on, 0 = power off; sampled at grant
- i_REQ_CLR  in  1  clear request; level signal
- i_REQ_DRAW  in  1  draw request; level signal
- o_GNT  out  3  one-hot grant: [0] power, [1] clear, [2] draw; held for the whole transaction
- o_DONE  out  3  one-cycle completion pulse per requester
- o_REJECT  out  3  one-cycle rejection pulse per requester; bit [0] is always 0
- o_POWERED  out  1  panel-on flag
- o_BUSY  out  1  high whenever the FSM is not in IDLE
- o_TIMEOUT  out  1  one-cycle timeout pulse; tied to 0 without the optional feature
- o_OLED_MODE  out  2  to OLED_interface i_MODE
- o_OLED_START  out  1  to OLED_interface i_START
- i_OLED_READY  in  1  from OLED_interface o_READY

Behaviour:
- Reset (asynchronous, i_RST=0): all outputs go to 0, o_OLED_MODE=MODE_ON, powered=0, round-robin pointer points to clear, FSM goes to IDLE. Reset mid-transaction abandons the transaction with no o_DONE pulse.
- FSM states: IDLE, ISSUE, BUSY, GAP.
- IDLE: arbitration runs only when i_OLED_READY=1 and at least one request is high.
  - Priority: power > {clear, draw}. Clear and draw alternate round-robin; the pointer moves past the winner after each grant.
- IDLE, power request, no transaction needed: i_PWR_DIR equals the current power state.
  - o_DONE[0] pulses on the next cycle with no OLED transaction.
  - FSM goes to GAP.
- IDLE, clear or draw request while powered=0:
  - The matching o_REJECT bit pulses on the next cycle and FSM goes to GAP.
  - A request still held after GAP is rejected again.
- IDLE, transaction granted:
  - o_GNT and o_OLED_MODE are registered.
  - Next cycle: ISSUE with o_OLED_START=1. Grant-to-START latency is 1 clock.
- ISSUE: hold o_OLED_START=1 and o_OLED_MODE steady until i_OLED_READY=0 is sampled. Then clear START and go to BUSY.
- BUSY: wait for i_OLED_READY=1. In that cycle:
  - o_DONE[gnt] is registered and pulses on the next cycle; o_GNT clears at the same time.
  - powered is set by MODE_ON and cleared by MODE_OFF.
  - FSM goes to GAP.
- GAP: count GAP_CYCLES clocks, then return to IDLE. With GAP_CYCLES=0, return to IDLE immediately.
- Request deasserted after grant: the transaction still completes and o_DONE still pulses.
- Power request arriving while a draw is in flight: it waits for the draw to finish and wins the next arbitration.
- o_OLED_MODE holds its last value outside transactions.

Optional Feature:
- Macro: OLED_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ISSUE and increments in ISSUE and BUSY.
  - On reaching ACK_TIMEOUT, the block pulses o_TIMEOUT, drops o_OLED_START and o_GNT, and goes to GAP.
  - No o_DONE pulse is issued and powered is unchanged.
- Without the macro: no counter is built, o_TIMEOUT=0, and the FSM waits indefinitely.

Test Plan:
1. Draw request while unpowered: i_REQ_DRAW=1 after reset with READY=1 -> o_REJECT=3'b100 for 1 cycle; o_OLED_START never asserts.
2. Power on: i_REQ_PWR=1, i_PWR_DIR=1; model drops READY 3 clocks after START and raises it 10 clocks later -> o_OLED_MODE=2'b00, START held exactly until READY falls, o_DONE=3'b001, o_POWERED=1.
3. Clear/draw fairness: powered on, i_REQ_CLR and i_REQ_DRAW held high for 4 transactions -> grant order 010, 100, 010, 100 with modes 2'b10 and 2'b11; at least GAP_CYCLES=2 idle clocks between START pulses.
4. Power priority: draw in flight when i_REQ_PWR=1 with i_PWR_DIR=0 is raised alongside i_REQ_CLR -> draw completes, power-off is granted next (mode 2'b01), o_POWERED=0, then clear is rejected.
5. Reset mid-operation: i_RST=0 during BUSY -> all outputs 0 asynchronously, o_POWERED=0, and no o_DONE pulse afterwards.
6. Timeout (OLED_ARB_TIMEOUT_EN defined, ACK_TIMEOUT=16): READY never falls -> o_TIMEOUT pulses 16 clocks after START, START drops, no o_DONE, and FSM returns to IDLE after the gap.
